// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: 2W-bit dividend by W-bit divisor,
// one quotient bit per clock, START/DONE handshake shared with the multiplier.
module restoring_divider #(
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
  input  logic [2*W-1:0] LOADA,
  input  logic [W-1:0]   LOADB,
  output logic [W-1:0]   QUOT,
  output logic [W-1:0]   REM,
  output logic           ERR,
  output logic           BUSY,
  output logic           DONE
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t         state_r;
  logic [2*W:0]   r_r;
  logic [W-1:0]   d_r;
  logic [CW-1:0]  count_r;
  logic           err_r;

  logic [W+1:0]   hi_s;
  logic [W:0]     trial_s;
  logic           trial_ok_s;

  // Trial subtraction on the partial remainder after the left shift
  always_comb begin
    hi_s       = r_r[2*W:W-1];
    trial_s    = hi_s[W:0] - {1'b0, d_r};
    trial_ok_s = (hi_s >= {2'b00, d_r});
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= S_IDLE;
      r_r     <= {(2*W+1){1'b0}};
      d_r     <= {W{1'b0}};
      count_r <= {CW{1'b0}};
      err_r   <= 1'b0;
      QUOT    <= {W{1'b0}};
      REM     <= {W{1'b0}};
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            r_r     <= {1'b0, LOADA};
            d_r     <= LOADB;
            count_r <= CW'(W);
            BUSY    <= 1'b1;
            // Zero divisor, or a quotient that cannot fit in W bits
            if ((LOADB == {W{1'b0}}) || (LOADA[2*W-1:W] >= LOADB)) begin
              err_r   <= 1'b1;
              state_r <= S_FIN;
            end else begin
              err_r   <= 1'b0;
              state_r <= S_CALC;
            end
          end else begin
            BUSY <= 1'b0;
          end
        end
        S_CALC: begin
          if (trial_ok_s) begin
            r_r <= {trial_s, r_r[W-2:0], 1'b1};
          end else begin
            r_r <= {hi_s[W:0], r_r[W-2:0], 1'b0};
          end
          count_r <= count_r - CW'(1);
          if (count_r == CW'(1)) begin
            state_r <= S_FIN;
          end else begin
            state_r <= S_CALC;
          end
        end
        S_FIN: begin
          if (err_r) begin
            QUOT <= {W{1'b1}};
            REM  <= r_r[W-1:0];
            ERR  <= 1'b1;
          end else begin
            QUOT <= r_r[W-1:0];
            REM  <= r_r[2*W-1:W];
            ERR  <= 1'b0;
          end
          DONE    <= 1'b1;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and randomised self-checking bench for restoring_divider (W=8).
module tb_restoring_divider;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [15:0] LOADA;
  logic [7:0]  LOADB;
  logic [7:0]  QUOT;
  logic [7:0]  REM;
  logic        ERR;
  logic        BUSY;
  logic        DONE;

  int n_cmp  = 0;
  int n_fail = 0;

  restoring_divider #(.W(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .LOADA (LOADA),
    .LOADB (LOADB),
    .QUOT  (QUOT),
    .REM   (REM),
    .ERR   (ERR),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with START for one accept edge; returns 1 time unit after it
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge CLK);
    LOADA = a;
    LOADB = b;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  // Count edges until DONE is seen, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
      if (DONE) break;
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] q, input logic [7:0] r, input logic e);
    check({tag, ".quot"}, 32'(QUOT), 32'(q));
    check({tag, ".rem"},  32'(REM),  32'(r));
    check({tag, ".err"},  32'(ERR),  32'(e));
  endtask

  initial begin
    int          lat;
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  eq;
    logic [7:0]  er;
    logic        ee;

    RST_N = 1'b0;
    START = 1'b0;
    LOADA = 16'h0000;
    LOADB = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check_res("reset", 8'h00, 8'h00, 1'b0);
    check("reset.busy", 32'(BUSY), 32'd0);
    check("reset.done", 32'(DONE), 32'd0);
    RST_N = 1'b1;

    // 1000 / 7 = 142 r 6
    start_op(16'd1000, 8'd7);
    check("op1.busy_after_accept", 32'(BUSY), 32'd1);
    check("op1.done_after_accept", 32'(DONE), 32'd0);
    check("op1.quot_held", 32'(QUOT), 32'd0);
    wait_done(lat);
    check("op1.latency", 32'(lat), 32'd9);
    check_res("op1", 8'd142, 8'd6, 1'b0);
    check("op1.busy_with_done", 32'(BUSY), 32'd1);
    @(posedge CLK);
    #1;
    check("op1.done_pulse", 32'(DONE), 32'd0);
    check("op1.busy_low", 32'(BUSY), 32'd0);

    start_op(16'hFE01, 8'hFF);
    check("op2.quot_held", 32'(QUOT), 32'd142);
    wait_done(lat);
    check("op2.latency", 32'(lat), 32'd9);
    check_res("op2", 8'hFF, 8'h00, 1'b0);

    start_op(16'h00FF, 8'h01);
    wait_done(lat);
    check_res("op3", 8'hFF, 8'h00, 1'b0);

    // Divide by zero: 1234 = 0x04D2
    start_op(16'd1234, 8'h00);
    wait_done(lat);
    check("div0.latency", 32'(lat), 32'd1);
    check_res("div0", 8'hFF, 8'hD2, 1'b1);

    start_op(16'hFFFF, 8'hFF);
    wait_done(lat);
    check("ovf.latency", 32'(lat), 32'd1);
    check_res("ovf", 8'hFF, 8'hFF, 1'b1);

    // START with new operands mid-CALC must be ignored
    start_op(16'd1000, 8'd7);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    LOADA = 16'h4000;
    LOADB = 8'd3;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(lat);
    check("ignore.latency", 32'(lat), 32'd5);
    check_res("ignore", 8'd142, 8'd6, 1'b0);
    @(posedge CLK);
    #1;
    check("ignore.busy_low", 32'(BUSY), 32'd0);

    // START held high: back-to-back, DONE every 10 cycles
    @(negedge CLK);
    LOADA = 16'd1000;
    LOADB = 8'd7;
    START = 1'b1;
    @(posedge CLK);
    #1;
    wait_done(lat);
    check("held.first_latency", 32'(lat), 32'd9);
    wait_done(lat);
    check("held.period", 32'(lat), 32'd10);
    check_res("held", 8'd142, 8'd6, 1'b0);
    START = 1'b0;
    @(posedge CLK);
    #1;
    check("held.busy_low", 32'(BUSY), 32'd0);
    check("held.done_low", 32'(DONE), 32'd0);

    // Reset mid-operation after four iterations
    start_op(16'hFE01, 8'hFF);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    check_res("midrst", 8'h00, 8'h00, 1'b0);
    check("midrst.busy", 32'(BUSY), 32'd0);
    check("midrst.done", 32'(DONE), 32'd0);
    RST_N = 1'b1;
    // 0x1234 / 0x56 = 4660 / 86 = 54 r 16
    start_op(16'h1234, 8'h56);
    wait_done(lat);
    check("postrst.latency", 32'(lat), 32'd9);
    check_res("postrst", 8'd54, 8'd16, 1'b0);

    // Random sweep, biased towards non-overflowing dividends
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 8'($urandom_range(0, 255));
      if (($urandom_range(0, 3) != 0) && (b != 8'h00)) begin
        a[15:8] = a[15:8] % b;
      end
      ee = (b == 8'h00) || (a[15:8] >= b);
      if (ee) begin
        eq = 8'hFF;
        er = a[7:0];
      end else begin
        eq = 8'(a / b);
        er = 8'(a % b);
      end
      start_op(a, b);
      wait_done(lat);
      check("rnd.latency", 32'(lat), ee ? 32'd1 : 32'd9);
      check_res("rnd", eq, er, ee);
      if (!ee) begin
        check("rnd.invariant", 32'(QUOT) * 32'(b) + 32'(REM), 32'(a));
        check("rnd.rem_lt_b", 32'(REM < b), 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
